// File: rtl/cineraria_core_bootmem_loader.sv
// Streams a block of words into an Avalon-MM memory, keeping a running checksum,
// and can optionally read the block back to confirm its sum.
module cineraria_core_bootmem_loader #(
    parameter int ADDR_W       = 14,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              verify_en,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum,
    input  logic [31:0]       snk_data,
    input  logic              snk_valid,
    output logic              snk_ready,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic              avm_read,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata
);
    typedef enum logic [2:0] {IDLE, WRITE, VREAD, VWAIT, FIN} state_t;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam int              LAT_W   = 2;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [31:0]       checksum_q, checksum_d;
    logic [31:0]       rsum_q, rsum_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              verify_q, verify_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [LAT_W-1:0]  lat_q, lat_d;

    logic [ADDR_W:0]   len_sat;
    logic [ADDR_W:0]   idx_next;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] nxt_addr;
    logic              wr_done;
    logic              accept;

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        checksum_d = checksum_q;
        rsum_d     = rsum_q;
        idx_d      = idx_q;
        len_d      = len_q;
        base_d     = base_q;
        verify_d   = verify_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lat_d      = lat_q;

        len_sat  = (length > MAX_LEN) ? MAX_LEN : length;
        idx_next = idx_q + 1'b1;
        cur_addr = base_q + idx_q[ADDR_W-1:0];
        nxt_addr = base_q + idx_next[ADDR_W-1:0];
        wr_done  = wr_q && !avm_waitrequest;
        // The holding register may refill in the same cycle its word is taken by the slave.
        snk_ready = (state_q == WRITE) && (idx_q < len_q) && (!wr_q || !avm_waitrequest);
        accept    = snk_valid && snk_ready;

        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d     = 1'b1;
                    error_d    = 1'b0;
                    checksum_d = 32'd0;
                    idx_d      = '0;
                    base_d     = base_addr;
                    len_d      = len_sat;
                    verify_d   = verify_en;
                    state_d    = (len_sat == '0) ? FIN : WRITE;
                end
            end
            WRITE: begin
                if (accept) begin
                    wr_d       = 1'b1;
                    addr_d     = cur_addr;
                    wdata_d    = snk_data;
                    checksum_d = checksum_q + snk_data;
                    idx_d      = idx_next;
                end else if (wr_done) begin
                    wr_d = 1'b0;
                    if (idx_q == len_q) begin
                        if (verify_q) begin
                            state_d = VREAD;
                            idx_d   = '0;
                            rsum_d  = 32'd0;
                            rd_d    = 1'b1;
                            addr_d  = base_q;
                        end else begin
                            state_d = FIN;
                        end
                    end
                end
            end
            VREAD: begin
                if (!avm_waitrequest) begin
                    rd_d    = 1'b0;
                    lat_d   = '0;
                    state_d = VWAIT;
                end
            end
            VWAIT: begin
                if (lat_q == LAT_LAST) begin
                    rsum_d = rsum_q + avm_readdata;
                    idx_d  = idx_next;
                    if (idx_next < len_q) begin
                        state_d = VREAD;
                        rd_d    = 1'b1;
                        addr_d  = nxt_addr;
                    end else begin
                        state_d = FIN;
                        error_d = ((rsum_q + avm_readdata) != checksum_q);
                    end
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            checksum_q <= 32'd0;
            rsum_q     <= 32'd0;
            idx_q      <= '0;
            len_q      <= '0;
            base_q     <= '0;
            verify_q   <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            lat_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            checksum_q <= checksum_d;
            rsum_q     <= rsum_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            base_q     <= base_d;
            verify_q   <= verify_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lat_q      <= lat_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign checksum       = checksum_q;
    assign avm_address    = addr_q;
    assign avm_writedata  = wdata_q;
    assign avm_write      = wr_q;
    assign avm_read       = rd_q;
    assign avm_chipselect = wr_q | rd_q;
    assign avm_byteenable = 4'hF;
endmodule

// File: doc/cineraria_core_bootmem_loader.md
CINERARIA_CORE_BOOTMEM_LOADER -- requirements
Module: cineraria_core_bootmem_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 14, giving the Avalon-MM word-address width.
REQ-002 The block SHALL have parameter READ_LATENCY, default 1, giving the fixed slave read latency in cycles (1..4).
REQ-003 clk  in  1  single clock; all logic is rising-edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to begin a load.
REQ-006 base_addr  in  ADDR_W  first word address, sampled on an accepted start.
REQ-007 length  in  ADDR_W+1  word count, sampled on an accepted start; values above 2^ADDR_W saturate to 2^ADDR_W.
REQ-008 verify_en  in  1  readback-verify request, sampled on an accepted start.
REQ-009 busy  out  1  high from the cycle after an accepted start until done.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 error  out  1  verify mismatch flag; held until the next accepted start or reset.
REQ-012 checksum  out  32  mod-2^32 sum of the words written; held after done.
REQ-013 snk_data  in  32  stream word.
REQ-014 snk_valid  in  1  stream valid.
REQ-015 snk_ready  out  1  stream ready; a word transfers when valid and ready are both high.
REQ-016 avm_address  out  ADDR_W  word address.
REQ-017 avm_byteenable  out  4  always 4'hF.
REQ-018 avm_chipselect  out  1  equals avm_write OR avm_read.
REQ-019 avm_write  out  1  write request.
REQ-020 avm_read  out  1  read request.
REQ-021 avm_writedata  out  32  write data.
REQ-022 avm_waitrequest  in  1  slave stall; tied 0 for on-chip RAM.
REQ-023 avm_readdata  in  32  valid exactly READ_LATENCY cycles after the cycle a read is accepted.

Function
REQ-024 The FSM SHALL have states IDLE, WRITE, VREAD, VWAIT and FIN.
REQ-025 start SHALL be accepted only in IDLE; start in any other state is ignored.
REQ-026 On an accepted start, the block SHALL clear checksum, error and the index, and enter WRITE; if the saturated length is 0, it SHALL enter FIN instead.
REQ-027 Addresses SHALL be (base_addr + index) mod 2^ADDR_W, with the index counting 0..length-1, so that addresses wrap past the top of memory.
REQ-028 In WRITE, snk_ready SHALL equal (holding register empty) OR (avm_write AND NOT avm_waitrequest), and SHALL be low once length words have been accepted.
REQ-029 Each accepted word SHALL drive avm_write, avm_writedata and avm_address on the next cycle.
REQ-030 While avm_waitrequest is high, avm_write, avm_writedata and avm_address SHALL be held stable.
REQ-031 Sustained throughput with avm_waitrequest=0 SHALL be 1 word per cycle.
REQ-032 checksum SHALL add each word when it is accepted from the stream.
REQ-033 When the last write completes (avm_write high and avm_waitrequest low), the FSM SHALL enter VREAD if verify_en was sampled high; otherwise it SHALL enter FIN.
REQ-034 On entry to VREAD, the index SHALL be reset to 0 and a read sum SHALL be cleared.
REQ-035 In VREAD, avm_read SHALL be asserted at the indexed address and held until avm_waitrequest is low; the FSM then enters VWAIT.
REQ-036 VWAIT SHALL last READ_LATENCY cycles, then add avm_readdata to the read sum and increment the index.
REQ-037 From VWAIT, the FSM SHALL enter VREAD if words remain; otherwise it SHALL enter FIN.
REQ-038 At the end of verify, error SHALL be set when the read sum is not equal to checksum.
REQ-039 FIN SHALL pulse done for one cycle, drop busy in the same cycle, and return to IDLE.
REQ-040 avm_write and avm_read SHALL never be high in the same cycle.
REQ-041 Outside WRITE, snk_ready SHALL be 0.

Reset
REQ-042 reset SHALL force the FSM to IDLE and drive to 0: busy, done, error, checksum, snk_ready, avm_write, avm_read, avm_chipselect, avm_address and avm_writedata.
REQ-043 When reset is asserted mid-operation, any in-flight transaction SHALL be abandoned with no further bus activity, and no done pulse SHALL be generated.
REQ-044 avm_byteenable SHALL remain 4'hF through reset.

Verification
REQ-045 base 0x0010, length 4, verify off, words 1,2,3,4 streamed back-to-back -> writes to 0x10..0x13 on consecutive cycles; checksum=0x0000000A; one done pulse; error=0.
REQ-046 base 0x3FFE, length 4 -> write addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001.
REQ-047 avm_waitrequest held high for 3 cycles during the second write -> address and data held stable; no stream word lost; checksum correct.
REQ-048 verify on, model RAM with READ_LATENCY=1 -> reads 0x10..0x13 after the writes; error=0. Same test with the readback of 0x12 forced to 0xDEADBEEF -> error=1 after done.
REQ-049 length 0 -> no avm_write or avm_read; done pulses 2 cycles after start; checksum=0. length 0x7FFF -> exactly 16384 writes.
REQ-050 reset asserted mid-WRITE after 2 of 8 words -> outputs are 0 the next cycle; no done pulse; a new start then runs cleanly.
